// File: rtl/tc_pkg.sv
// tc_pkg: shared definitions for the tc_multi timer/counter peripheral.
//   - channel mode encodings (one-shot, auto-reload, square-wave)
//   - CTRL register bit positions
//   - per-channel register offsets and the STATUS address helper
// Optional build macro seen by users of this package: TC_PRESCALE_EN.
package tc_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_SQUARE  = 2'b10,
        MODE_RSVD    = 2'b11
    } tc_mode_e;

    // CTRL register layout
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_PS_LSB   = 4;

    // Word offsets inside a channel's 4-word window
    localparam int OFF_CTRL   = 0;
    localparam int OFF_PRESET = 1;
    localparam int OFF_COUNT  = 2;

    // STATUS sits right after the last channel window
    function automatic int status_addr(input int n_ch);
        return 4 * n_ch;
    endfunction

endpackage

// File: rtl/tc_channel.sv
// tc_channel: one down-counter channel of tc_multi.
// Holds EN, MODE, COUNT, WAVE and (with TC_PRESCALE_EN) PS and the 8-bit
// prescaler; emits a one-cycle event pulse that the top latches into STATUS.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_ctrl_we         CTRL register of this channel written this cycle
//   i_ctrl_dat        low byte of the bus write data
//   i_preset          PRESET register (held in the top)
//   o_en, o_mode, o_ps  CTRL fields for read-back
//   o_count, o_wave   counter value and square-wave level
//   o_event           combinational event pulse, valid at the coming edge
module tc_channel
    import tc_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ctrl_we,
    input  logic [7:0]       i_ctrl_dat,
    input  logic [CNT_W-1:0] i_preset,
    output logic             o_en,
    output logic [1:0]       o_mode,
    output logic [3:0]       o_ps,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wave,
    output logic             o_event
);

    logic             r_en;
    tc_mode_e         r_mode;
    logic [CNT_W-1:0] r_count;
    logic             r_wave;

    logic             w_en_eff;
    tc_mode_e         w_mode_eff;
    logic             w_start;
    logic             w_tick;
    logic             w_at_end;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_count_next;
    logic             w_en_next;
    logic             w_wave_next;
    logic             w_event;

    // A CTRL write in this cycle governs this cycle's update.
    assign w_en_eff   = i_ctrl_we ? i_ctrl_dat[CTRL_EN_BIT] : r_en;
    assign w_mode_eff = i_ctrl_we ? tc_mode_e'(i_ctrl_dat[CTRL_MODE_LSB +: 2]) : r_mode;
    assign w_start    = i_ctrl_we & i_ctrl_dat[CTRL_EN_BIT] & ~r_en;
    assign w_half     = ((i_preset >> 1) == '0) ? CNT_W'(1) : (i_preset >> 1);
    assign w_at_end   = (r_count <= CNT_W'(1));

`ifdef TC_PRESCALE_EN
    logic [3:0] r_ps;
    logic [7:0] r_psc;
    logic [3:0] w_ps_eff;
    logic [7:0] w_mask;
    logic       w_unused_ctrl;

    assign w_ps_eff = i_ctrl_we ? i_ctrl_dat[CTRL_PS_LSB +: 4] : r_ps;
    // PS >= 8 saturates to all eight prescaler bits
    assign w_mask   = (w_ps_eff >= 4'd8) ? 8'hFF : 8'((9'd1 << w_ps_eff) - 9'd1);
    assign w_tick   = w_en_eff & ((r_psc & w_mask) == w_mask);
    assign o_ps     = r_ps;
    assign w_unused_ctrl = i_ctrl_dat[CTRL_IM_BIT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ps  <= 4'd0;
            r_psc <= 8'd0;
        end else begin
            if (i_ctrl_we) begin
                r_ps <= w_ps_eff;
            end
            if (w_start || !w_en_eff) begin
                r_psc <= 8'd0;
            end else begin
                r_psc <= r_psc + 8'd1;
            end
        end
    end
`else
    logic w_unused_ctrl;

    assign w_tick = w_en_eff;
    assign o_ps   = 4'd0;
    assign w_unused_ctrl = ^i_ctrl_dat[7:3];
`endif

    always_comb begin
        w_count_next = r_count;
        w_en_next    = w_en_eff;
        w_wave_next  = r_wave;
        w_event      = 1'b0;
        if (w_start) begin
            // start load wins over any tick in the same cycle
            w_count_next = (w_mode_eff == MODE_SQUARE) ? w_half : i_preset;
            w_wave_next  = 1'b0;
        end else if (w_tick) begin
            case (w_mode_eff)
                MODE_ONESHOT: begin
                    if (w_at_end) begin
                        w_count_next = '0;
                        w_en_next    = 1'b0;
                        w_event      = 1'b1;
                    end else begin
                        w_count_next = r_count - CNT_W'(1);
                    end
                end
                MODE_RELOAD: begin
                    if (w_at_end) begin
                        w_count_next = i_preset;
                        w_event      = 1'b1;
                    end else begin
                        w_count_next = r_count - CNT_W'(1);
                    end
                end
                MODE_SQUARE: begin
                    if (w_at_end) begin
                        w_count_next = w_half;
                        w_wave_next  = ~r_wave;
                        w_event      = ~r_wave;  // only the rising toggle
                    end else begin
                        w_count_next = r_count - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en    <= 1'b0;
            r_mode  <= MODE_ONESHOT;
            r_count <= '0;
            r_wave  <= 1'b0;
        end else begin
            r_en    <= w_en_next;
            r_count <= w_count_next;
            r_wave  <= w_wave_next;
            if (i_ctrl_we) begin
                r_mode <= w_mode_eff;
            end
        end
    end

    assign o_en    = r_en;
    assign o_mode  = r_mode;
    assign o_count = r_count;
    assign o_wave  = r_wave;
    assign o_event = w_event;

endmodule

// File: rtl/tc_multi.sv
// tc_multi: N_CH-channel memory-mapped timer/counter.
// Address decode, read mux, PRESET/IM registers, sticky W1C STATUS and IRQ.
// Build macro: TC_PRESCALE_EN enables the per-channel 8-bit prescaler.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_add          word address
//   i_stb, i_we    bus strobe and write enable (write when both high)
//   i_dat          write data
//   o_dat          read data, combinational from i_add
//   o_irq          per-channel interrupt = STATUS & IM
//   o_wave         per-channel square-wave level
module tc_multi
    import tc_pkg::*;
#(
    parameter int N_CH   = 3,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 4
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_add,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [31:0]       i_dat,
    output logic [31:0]       o_dat,
    output logic [N_CH-1:0]   o_irq,
    output logic [N_CH-1:0]   o_wave
);

    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_addr(N_CH));

    logic                        w_wr;
    logic [N_CH-1:0]             r_status;
    logic [N_CH-1:0]             w_im;
    logic [N_CH-1:0]             w_en;
    logic [N_CH-1:0]             w_event;
    logic [N_CH-1:0][1:0]        w_mode;
    logic [N_CH-1:0][3:0]        w_ps;
    logic [N_CH-1:0][CNT_W-1:0]  w_count;
    logic [N_CH-1:0][CNT_W-1:0]  w_preset;
    logic [N_CH-1:0]             w_status_clr;
    logic                        w_unused_dat;

    assign w_wr         = i_stb & i_we;
    assign w_unused_dat = ^i_dat;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic             r_im;
            logic [CNT_W-1:0] r_preset;
            logic             w_ctrl_we;

            assign w_ctrl_we = w_wr & (i_add == ADDR_W'(4 * gi + OFF_CTRL));

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_im     <= 1'b0;
                    r_preset <= '0;
                end else begin
                    if (w_ctrl_we) begin
                        r_im <= i_dat[CTRL_IM_BIT];
                    end
                    if (w_wr && (i_add == ADDR_W'(4 * gi + OFF_PRESET))) begin
                        r_preset <= i_dat[CNT_W-1:0];
                    end
                end
            end

            assign w_im[gi]     = r_im;
            assign w_preset[gi] = r_preset;

            tc_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_ctrl_we  (w_ctrl_we),
                .i_ctrl_dat (i_dat[7:0]),
                .i_preset   (r_preset),
                .o_en       (w_en[gi]),
                .o_mode     (w_mode[gi]),
                .o_ps       (w_ps[gi]),
                .o_count    (w_count[gi]),
                .o_wave     (o_wave[gi]),
                .o_event    (w_event[gi])
            );
        end
    endgenerate

    always_comb begin
        o_dat = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (i_add == ADDR_W'(4 * c + OFF_CTRL)) begin
                o_dat = {24'd0, w_ps[c], w_im[c], w_mode[c], w_en[c]};
            end else if (i_add == ADDR_W'(4 * c + OFF_PRESET)) begin
                o_dat = 32'(w_preset[c]);
            end else if (i_add == ADDR_W'(4 * c + OFF_COUNT)) begin
                o_dat = 32'(w_count[c]);
            end
        end
        if (i_add == STATUS_ADDR) begin
            o_dat = 32'(r_status);
        end
    end

    assign w_status_clr = (w_wr && (i_add == STATUS_ADDR)) ? i_dat[N_CH-1:0] : '0;

    // Event set is OR-ed after the clear so a same-cycle event survives W1C.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_status_clr) | w_event;
        end
    end

    assign o_irq = r_status & w_im;

endmodule

// File: tb/tb_tc_multi.sv
// tb_tc_multi: scoreboard bench for tc_multi. A driver issues one bus cycle
// per clock and pushes the expected DAT_O/IRQ/WAVE of that cycle (from a
// behavioural model) into a queue; a monitor pops and compares on negedge.
module tb_tc_multi;

    localparam int N_CH   = 3;
    localparam int CNT_W  = 32;
    localparam int ADDR_W = 4;
    localparam int STAT_A = 4 * N_CH;
    localparam longint unsigned MASK = (CNT_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                     : ((64'd1 << CNT_W) - 64'd1);
`ifdef TC_PRESCALE_EN
    localparam bit PS_ON = 1'b1;
`else
    localparam bit PS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] add;
    logic              stb;
    logic              we;
    logic [31:0]       dat_i;
    logic [31:0]       dat_o;
    logic [N_CH-1:0]   irq;
    logic [N_CH-1:0]   wave;

    always #5 clk = ~clk;

    tc_multi #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_add  (add),
        .i_stb  (stb),
        .i_we   (we),
        .i_dat  (dat_i),
        .o_dat  (dat_o),
        .o_irq  (irq),
        .o_wave (wave)
    );

    typedef struct {
        logic [31:0]     dat;
        logic [N_CH-1:0] irq;
        logic [N_CH-1:0] wave;
        bit              has_c;
        logic [31:0]     cdat;
        int              ph;
        int              a;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   phase  = 0;

    // ---------------- behavioural model ----------------
    bit              m_en   [N_CH];
    int              m_mode [N_CH];
    bit              m_im   [N_CH];
    int              m_ps   [N_CH];
    longint unsigned m_pre  [N_CH];
    longint unsigned m_cnt  [N_CH];
    bit              m_wave [N_CH];
    int              m_psc  [N_CH];
    bit              m_stat [N_CH];

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_ps[c] = 0;
            m_pre[c] = 0; m_cnt[c] = 0; m_wave[c] = 0; m_psc[c] = 0; m_stat[c] = 0;
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        int s;
        for (int c = 0; c < N_CH; c++) begin
            if (a == 4 * c)
                return 32'(((PS_ON ? m_ps[c] : 0) << 4) | (int'(m_im[c]) << 3)
                           | (m_mode[c] << 1) | int'(m_en[c]));
            if (a == 4 * c + 1) return 32'(m_pre[c]);
            if (a == 4 * c + 2) return 32'(m_cnt[c]);
        end
        if (a == STAT_A) begin
            s = 0;
            for (int c = 0; c < N_CH; c++) s = s | (int'(m_stat[c]) << c);
            return 32'(s);
        end
        return 32'd0;
    endfunction

    function automatic logic [N_CH-1:0] model_irq();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = m_stat[c] & m_im[c];
        return v;
    endfunction

    function automatic logic [N_CH-1:0] model_wave();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = m_wave[c];
        return v;
    endfunction

    task automatic model_step(input int a, input bit s, input bit w,
                              input logic [31:0] d, input bit r);
        bit              wr;
        bit              ev [N_CH];
        bit              cw, en, start, tick;
        int              mode, ps, msk;
        longint unsigned half;
        if (r) begin
            model_reset();
            return;
        end
        wr = s && w;
        for (int c = 0; c < N_CH; c++) begin
            ev[c] = 0;
            cw    = wr && (a == 4 * c);
            en    = cw ? d[0] : m_en[c];
            mode  = cw ? int'(d[2:1]) : m_mode[c];
            ps    = cw ? int'(d[7:4]) : m_ps[c];
            start = cw && d[0] && !m_en[c];
            half  = m_pre[c] / 2;
            if (half == 0) half = 1;
            msk   = (1 << ps) - 1;
            tick  = en && (!PS_ON || ((m_psc[c] & msk) == msk));
            if (start) begin
                m_cnt[c]  = (mode == 2) ? half : m_pre[c];
                m_wave[c] = 0;
            end else if (tick) begin
                if (mode == 3) begin
                    // reserved: counter holds
                end else if (m_cnt[c] > 1) begin
                    m_cnt[c] = m_cnt[c] - 1;
                end else if (mode == 0) begin
                    m_cnt[c] = 0; en = 0; ev[c] = 1;
                end else if (mode == 1) begin
                    m_cnt[c] = m_pre[c]; ev[c] = 1;
                end else begin
                    m_cnt[c]  = half;
                    ev[c]     = !m_wave[c];
                    m_wave[c] = !m_wave[c];
                end
            end
            if (start || !(cw ? d[0] : m_en[c])) m_psc[c] = 0;
            else m_psc[c] = (m_psc[c] + 1) & 255;
            m_en[c] = en;
            if (cw) begin
                m_mode[c] = mode;
                m_im[c]   = d[3];
                m_ps[c]   = PS_ON ? ps : 0;
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            if (wr && a == 4 * c + 1) m_pre[c] = longint'(d) & MASK;
            if (wr && a == STAT_A && d[c]) m_stat[c] = 0;
            if (ev[c]) m_stat[c] = 1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input int a, input bit s, input bit w, input logic [31:0] d,
                        input bit r = 1'b0, input bit hc = 1'b0, input logic [31:0] cd = 32'd0);
        exp_t e;
        add = ADDR_W'(a); stb = s; we = w; dat_i = d; rst = r;
        e.dat = model_read(a); e.irq = model_irq(); e.wave = model_wave();
        e.has_c = hc; e.cdat = cd; e.ph = phase; e.a = a;
        exp_q.push_back(e);
        @(posedge clk);
        model_step(a, s, w, d, r);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        step(a, 1'b1, 1'b1, d);
    endtask

    task automatic rd(input int a);
        step(a, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic rdc(input int a, input logic [31:0] c);
        step(a, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, c);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("txn ph=%0d add=%0d dat_o=%h irq=%b wave=%b", e.ph, e.a, dat_o, irq, wave);
            checks++;
            if (dat_o !== e.dat) begin
                errors++;
                $display("FAIL dat_o ph=%0d add=%0d got=%h exp=%h", e.ph, e.a, dat_o, e.dat);
            end
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL irq ph=%0d add=%0d got=%b exp=%b", e.ph, e.a, irq, e.irq);
            end
            checks++;
            if (wave !== e.wave) begin
                errors++;
                $display("FAIL wave ph=%0d add=%0d got=%b exp=%b", e.ph, e.a, wave, e.wave);
            end
            if (e.has_c) begin
                checks++;
                if (dat_o !== e.cdat) begin
                    errors++;
                    $display("FAIL const_rd ph=%0d add=%0d got=%h exp=%h", e.ph, e.a, dat_o, e.cdat);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          a;
        logic [31:0] d;
        rst = 1'b1; stb = 1'b0; we = 1'b0; add = '0; dat_i = '0;
        repeat (3) @(posedge clk);
        model_reset();
        #1;

        // reset state: every address reads 0
        phase = 1;
        for (int i = 0; i < 16; i++) rdc(i, 32'd0);

        // ch0 one-shot, IM=1
        phase = 2;
        wr(1, 32'd3); wr(0, 32'h9);
        rdc(2, 32'd3); rdc(2, 32'd2); rdc(2, 32'd1); rdc(2, 32'd0);
        rdc(0, 32'h8); rdc(STAT_A, 32'd1);
        wr(STAT_A, 32'd1); rdc(STAT_A, 32'd0);

        // ch1 auto-reload, IM=0; W1C collides with an event
        phase = 3;
        wr(5, 32'd4); wr(4, 32'h3);
        rdc(STAT_A, 32'd0); rdc(STAT_A, 32'd0); rdc(STAT_A, 32'd0);
        wr(STAT_A, 32'd2);
        rdc(STAT_A, 32'd2);
        wr(4, 32'h3);            // EN=1 while running: no reload
        rdc(6, 32'd2);
        wr(4, 32'h2);            // EN=0 freezes
        wr(STAT_A, 32'd2);
        rdc(6, 32'd1); rdc(STAT_A, 32'd0);

        // ch2 square wave, then PRESET=1 while running
        phase = 4;
        wr(9, 32'd6); wr(8, 32'h5);
        rdc(10, 32'd3); rdc(10, 32'd2); rdc(10, 32'd1); rdc(10, 32'd3);
        for (int i = 0; i < 10; i++) rd(STAT_A);
        wr(9, 32'd1);
        for (int i = 0; i < 10; i++) rd(10);
        wr(8, 32'h4);
        wr(STAT_A, 32'h7);

        // reset mid-count
        phase = 5;
        wr(5, 32'd5); wr(4, 32'h3); rd(6); rd(6);
        step(6, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 16; i++) rdc(i, 32'd0);

        // prescaler / PS field
        phase = 6;
`ifdef TC_PRESCALE_EN
        wr(1, 32'd2); wr(0, 32'h21);
        for (int i = 0; i < 4; i++) rdc(2, 32'd2);
        for (int i = 0; i < 4; i++) rdc(2, 32'd1);
        rdc(2, 32'd0); rdc(STAT_A, 32'd1); rdc(0, 32'h20);
`else
        wr(0, 32'hF8); rdc(0, 32'h08);
`endif
        wr(STAT_A, 32'h7);

        // randomized traffic against the model
        phase = 7;
        for (int i = 0; i < 250; i++) begin
            a = int'($urandom_range(0, 15));
            if ((a % 4) == 0 && a < STAT_A)
                d = ($urandom & 32'hFFFF_FF0F) | (32'($urandom_range(0, 3)) << 4);
            else if ((a % 4) == 1)
                d = 32'($urandom_range(0, 6));
            else
                d = $urandom;
            step(a, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, d,
                 $urandom_range(0, 199) == 0);
        end
        rd(STAT_A);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
